// File: rtl/cci_mpf_if.sv
// CCI-P channel 1 types used by the writeback engine: request/response
// headers and the Tx/Rx wrappers for one cache line per request.
package cci_mpf_if;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [1:0]   t_ccip_clNum;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic         format;
    t_ccip_clNum  cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

// File: rtl/glm_common.sv
// Shared GLM engine constants and the writeback FSM state type.
package glm_common;

  localparam int unsigned LOG2_WRITEBUF_SIZE = 6;
  localparam int unsigned WRITEBUF_SIZE      = 2 ** LOG2_WRITEBUF_SIZE;
  localparam int unsigned ALMFULL_SLACK      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FENCE,
    DONE
  } t_writeback_state;

endpackage

// File: rtl/normal2axis_fifo.sv
// Synchronous FIFO with a plain push side and a valid/ready (show-ahead) pop side.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_data      write strobe and data; a push into a full FIFO is dropped
//   almostfull           count >= depth - ALMFULL_SLACK
//   pop_valid, pop_data  head entry, presented whenever the FIFO is non-empty
//   pop_ready            consume the head entry this cycle
module normal2axis_fifo #(
  parameter int unsigned WIDTH         = 512,
  parameter int unsigned LOG2_DEPTH    = 6,
  parameter int unsigned ALMFULL_SLACK = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             almostfull,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_ready
);

  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH:0]   count;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign full       = (count == (LOG2_DEPTH + 1)'(DEPTH));
  assign almostfull = (count >= (LOG2_DEPTH + 1)'(DEPTH - ALMFULL_SLACK));
  assign pop_valid  = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign do_push    = push && !full;
  assign do_pop     = pop_ready && pop_valid;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (LOG2_DEPTH + 1)'(do_push) - (LOG2_DEPTH + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/execute_writeback.sv
// Write-side engine for CCI-P channel 1. In IDLE it is a registered pass-through between
// the engine (put_*) and the c1 port. On op_start it buffers regs1 engine line writes,
// re-addresses them to out_addr + regs0 + n, issues them under c1TxAlmFull, counts write
// acks and pulses op_done once every line is committed.
// Build option: define WRITEBACK_FENCE_EN to issue a write fence after the last ack and
// wait for its response before op_done.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   op_start/op_done   start pulse (IDLE only) / 1-cycle completion pulse
//   regs0, regs1       line offset from out_addr / number of lines
//   out_addr           base line address
//   c1TxAlmFull        c1 almost-full from the CCI-P side
//   cp2af_sRx_c1       c1 write responses
//   af2cp_sTx_c1       c1 write requests (registered)
//   put_c1TxAlmFull    back-pressure to the engine (registered)
//   put_af2cp_sTx_c1   engine write requests (address ignored while writing)
//   put_cp2af_sRx_c1   responses forwarded to the engine in IDLE only
module execute_writeback
  import cci_mpf_if::*;
#(
  parameter int unsigned LOG2_WRITEBUF_SIZE = glm_common::LOG2_WRITEBUF_SIZE,
  parameter int unsigned ALMFULL_SLACK      = glm_common::ALMFULL_SLACK
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           op_start,
  output logic           op_done,
  input  logic [31:0]    regs0,
  input  logic [31:0]    regs1,
  input  t_ccip_clAddr   out_addr,
  input  logic           c1TxAlmFull,
  input  t_if_ccip_c1_Rx cp2af_sRx_c1,
  output t_if_ccip_c1_Tx af2cp_sTx_c1,
  output logic           put_c1TxAlmFull,
  input  t_if_ccip_c1_Tx put_af2cp_sTx_c1,
  output t_if_ccip_c1_Rx put_cp2af_sRx_c1
);

  import glm_common::*;

  t_writeback_state state;
  t_ccip_clAddr     base;
  logic [31:0]      len;
  logic [31:0]      accepted;
  logic [31:0]      issued;
  logic [31:0]      acked;
  logic [31:0]      accepted_next;
  logic [31:0]      issued_next;
  logic [31:0]      acked_next;
  logic [31:0]      ack_inc;
  logic             write_exit;
  logic             buf_push;
  logic             buf_almfull;
  logic             buf_valid;
  t_ccip_clData     buf_data;
  logic             issue;
  t_if_ccip_c1_Tx   wr_req;

  assign buf_push = (state == WRITE) && put_af2cp_sTx_c1.valid && (accepted < len);
  assign issue    = (state == WRITE) && buf_valid && !c1TxAlmFull && (issued < len);

  normal2axis_fifo #(
    .WIDTH        ($bits(t_ccip_clData)),
    .LOG2_DEPTH   (LOG2_WRITEBUF_SIZE),
    .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .push      (buf_push),
    .push_data (put_af2cp_sTx_c1.data),
    .almostfull(buf_almfull),
    .pop_valid (buf_valid),
    .pop_data  (buf_data),
    .pop_ready (issue)
  );

  // A packed response (format=1) acknowledges cl_num+1 lines at once.
  always_comb begin
    ack_inc = '0;
    if (cp2af_sRx_c1.rspValid && (cp2af_sRx_c1.hdr.resp_type == eRSP_WRLINE)) begin
      ack_inc = cp2af_sRx_c1.hdr.format ? 32'(cp2af_sRx_c1.hdr.cl_num) + 32'd1 : 32'd1;
    end
  end

  assign accepted_next = accepted + 32'(buf_push);
  assign issued_next   = issued + 32'(issue);
  assign acked_next    = acked + ack_inc;
  // Uses this cycle's issue/ack so completion is seen on the edge that takes the last ack.
  assign write_exit    = (issued_next == len) && (acked_next == len);

  always_comb begin
    wr_req                  = '0;
    wr_req.valid            = issue;
    wr_req.hdr.vc_sel       = eVC_VA;
    wr_req.hdr.sop          = 1'b1;
    wr_req.hdr.cl_len       = eCL_LEN_1;
    wr_req.hdr.req_type     = eREQ_WRLINE_I;
    wr_req.hdr.address      = base + t_ccip_clAddr'(issued);
    wr_req.hdr.mdata        = issued[15:0];
    wr_req.data             = buf_data;
  end

`ifdef WRITEBACK_FENCE_EN
  logic           fence_sent;
  t_if_ccip_c1_Tx fence_req;

  always_comb begin
    fence_req              = '0;
    fence_req.valid        = 1'b1;
    fence_req.hdr.vc_sel   = eVC_VA;
    fence_req.hdr.sop      = 1'b1;
    fence_req.hdr.cl_len   = eCL_LEN_1;
    fence_req.hdr.req_type = eREQ_WRFENCE;
    fence_req.hdr.mdata    = 16'hFFFF;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      op_done          <= 1'b0;
      af2cp_sTx_c1     <= '0;
      put_cp2af_sRx_c1 <= '0;
      put_c1TxAlmFull  <= 1'b1;
      base             <= '0;
      len              <= '0;
      accepted         <= '0;
      issued           <= '0;
      acked            <= '0;
`ifdef WRITEBACK_FENCE_EN
      fence_sent       <= 1'b0;
`endif
    end else begin
      op_done          <= 1'b0;
      af2cp_sTx_c1     <= '0;
      put_cp2af_sRx_c1 <= '0;
      put_c1TxAlmFull  <= 1'b1;
      acked            <= acked_next;
      unique case (state)
        IDLE: begin
          af2cp_sTx_c1     <= put_af2cp_sTx_c1;
          put_cp2af_sRx_c1 <= cp2af_sRx_c1;
          put_c1TxAlmFull  <= c1TxAlmFull;
          if (op_start) begin
            base     <= out_addr + t_ccip_clAddr'(regs0);
            len      <= regs1;
            accepted <= '0;
            issued   <= '0;
            acked    <= '0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          accepted        <= accepted_next;
          issued          <= issued_next;
          af2cp_sTx_c1    <= wr_req;
          put_c1TxAlmFull <= c1TxAlmFull | buf_almfull | (accepted_next >= len);
          if (write_exit) begin
`ifdef WRITEBACK_FENCE_EN
            fence_sent <= 1'b0;
            state      <= FENCE;
`else
            op_done    <= 1'b1;
            state      <= DONE;
`endif
          end
        end
        FENCE: begin
`ifdef WRITEBACK_FENCE_EN
          if (!fence_sent && !c1TxAlmFull) begin
            af2cp_sTx_c1 <= fence_req;
            fence_sent   <= 1'b1;
          end
          if (fence_sent && cp2af_sRx_c1.rspValid &&
              (cp2af_sRx_c1.hdr.resp_type == eRSP_WRFENCE)) begin
            op_done <= 1'b1;
            state   <= DONE;
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_writeback.sv
module tb_execute_writeback;
  import cci_mpf_if::*;

`ifdef WRITEBACK_FENCE_EN
  localparam int FENCE = 1;
`else
  localparam int FENCE = 0;
`endif

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           op_start = 1'b0;
  logic           op_done;
  logic [31:0]    regs0 = '0;
  logic [31:0]    regs1 = '0;
  t_ccip_clAddr   out_addr = '0;
  logic           c1TxAlmFull = 1'b0;
  t_if_ccip_c1_Rx cp2af_sRx_c1;
  t_if_ccip_c1_Tx af2cp_sTx_c1;
  logic           put_c1TxAlmFull;
  t_if_ccip_c1_Tx put_af2cp_sTx_c1;
  t_if_ccip_c1_Rx put_cp2af_sRx_c1;

  execute_writeback dut (
    .clk             (clk),
    .resetn          (resetn),
    .op_start        (op_start),
    .op_done         (op_done),
    .regs0           (regs0),
    .regs1           (regs1),
    .out_addr        (out_addr),
    .c1TxAlmFull     (c1TxAlmFull),
    .cp2af_sRx_c1    (cp2af_sRx_c1),
    .af2cp_sTx_c1    (af2cp_sTx_c1),
    .put_c1TxAlmFull (put_c1TxAlmFull),
    .put_af2cp_sTx_c1(put_af2cp_sTx_c1),
    .put_cp2af_sRx_c1(put_cp2af_sRx_c1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // c1 request monitor and op_done counter
  logic         rec_en = 1'b0;
  logic [41:0]  mq_addr[$];
  logic [15:0]  mq_mdata[$];
  logic [63:0]  mq_data[$];
  logic [3:0]   mq_type[$];
  int wr_cnt = 0;
  int fence_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (rec_en && af2cp_sTx_c1.valid) begin
      mq_addr.push_back(af2cp_sTx_c1.hdr.address);
      mq_mdata.push_back(af2cp_sTx_c1.hdr.mdata);
      mq_data.push_back(af2cp_sTx_c1.data[63:0]);
      mq_type.push_back(af2cp_sTx_c1.hdr.req_type);
      if (af2cp_sTx_c1.hdr.req_type == eREQ_WRFENCE) fence_cnt <= fence_cnt + 1;
      else wr_cnt <= wr_cnt + 1;
    end
    if (op_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // Response generator: fences always answered, line acks when auto_ack, packed on request.
  logic auto_ack = 1'b0;
  int ack_sent = 0;
  int fence_acked = 0;
  int pack_req = 0;
  int pack_sent = 0;
  int last_ack_cyc = 0;
  int fence_rsp_cyc = 0;

  initial begin
    cp2af_sRx_c1 = '0;
    forever begin
      @(posedge clk);
      #1;
      cp2af_sRx_c1 = '0;
      if (!auto_ack) ack_sent = wr_cnt;
      if (pack_sent < pack_req) begin
        cp2af_sRx_c1.rspValid      = 1'b1;
        cp2af_sRx_c1.hdr.resp_type = eRSP_WRLINE;
        cp2af_sRx_c1.hdr.format    = 1'b1;
        cp2af_sRx_c1.hdr.cl_num    = 2'd3;
        pack_sent++;
        last_ack_cyc = cyc;
      end else if (fence_acked < fence_cnt) begin
        cp2af_sRx_c1.rspValid      = 1'b1;
        cp2af_sRx_c1.hdr.resp_type = eRSP_WRFENCE;
        cp2af_sRx_c1.hdr.mdata     = 16'hFFFF;
        fence_acked++;
        fence_rsp_cyc = cyc;
      end else if (auto_ack && ack_sent < wr_cnt) begin
        cp2af_sRx_c1.rspValid      = 1'b1;
        cp2af_sRx_c1.hdr.resp_type = eRSP_WRLINE;
        ack_sent++;
        last_ack_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int start_cyc = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_op(input logic [31:0] r0, input logic [31:0] r1, input t_ccip_clAddr a);
    regs0     = r0;
    regs1     = r1;
    out_addr  = a;
    op_start  = 1'b1;
    start_cyc = cyc;
    tick();
    op_start  = 1'b0;
  endtask

  task automatic put_line(input logic [63:0] d, input bit obey);
    int t = 0;
    if (obey) begin
      while (put_c1TxAlmFull && t < 2000) begin
        tick();
        t++;
      end
    end
    if (t >= 2000) check("put_backpressure_timeout", 64'(t), 64'd0);
    put_af2cp_sTx_c1                  = '0;
    put_af2cp_sTx_c1.valid            = 1'b1;
    put_af2cp_sTx_c1.data             = {8{d}};
    put_af2cp_sTx_c1.hdr.req_type     = eREQ_WRLINE_I;
    put_af2cp_sTx_c1.hdr.address      = 42'h3AB_CDEF;
    tick();
    put_af2cp_sTx_c1.valid            = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev, input int budget);
    int t = 0;
    while (done_cnt == prev && t < budget) begin
      tick();
      t++;
    end
    check(tag, 64'(done_cnt > prev), 64'd1);
  endtask

  int d0;
  int q0;
  int w0;
  int t;

  initial begin
    put_af2cp_sTx_c1 = '0;
    tick(3);
    // Reset values
    check("rst_op_done", 64'(op_done), 64'd0);
    check("rst_c1_valid", 64'(af2cp_sTx_c1.valid), 64'd0);
    check("rst_rsp_fwd", 64'(put_cp2af_sRx_c1.rspValid), 64'd0);
    check("rst_put_almfull", 64'(put_c1TxAlmFull), 64'd1);
    resetn = 1'b1;
    tick(2);

    // IDLE pass-through
    check("idle_almfull_fwd0", 64'(put_c1TxAlmFull), 64'd0);
    c1TxAlmFull = 1'b1;
    tick();
    check("idle_almfull_fwd1", 64'(put_c1TxAlmFull), 64'd1);
    c1TxAlmFull = 1'b0;
    put_af2cp_sTx_c1.valid        = 1'b1;
    put_af2cp_sTx_c1.hdr.address  = 42'h123;
    put_af2cp_sTx_c1.hdr.mdata    = 16'h55;
    tick();
    put_af2cp_sTx_c1.valid        = 1'b0;
    check("idle_req_valid", 64'(af2cp_sTx_c1.valid), 64'd1);
    check("idle_req_addr", 64'(af2cp_sTx_c1.hdr.address), 64'h123);
    check("idle_req_mdata", 64'(af2cp_sTx_c1.hdr.mdata), 64'h55);
    pack_req = pack_req + 1;
    t = 0;
    while (!put_cp2af_sRx_c1.rspValid && t < 6) begin
      tick();
      t++;
    end
    check("idle_rsp_fwd", 64'(put_cp2af_sRx_c1.rspValid), 64'd1);
    check("idle_rsp_clnum", 64'(put_cp2af_sRx_c1.hdr.cl_num), 64'd3);
    tick(3);

    // T1: 4 lines at 0x1000 + 0x10, immediate acks
    rec_en   = 1'b1;
    auto_ack = 1'b1;
    d0 = done_cnt;
    q0 = mq_addr.size();
    start_op(32'h10, 32'd4, 42'h1000);
    for (int i = 0; i < 4; i++) put_line(64'hA0 + 64'(i), 1'b1);
    wait_done("t1_done", d0, 200);
    tick(4);
    check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t1_req_count", 64'(mq_addr.size() - q0), 64'(4 + FENCE));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), 64'(mq_addr[q0 + i]), 64'h1010 + 64'(i));
      check($sformatf("t1_mdata%0d", i), 64'(mq_mdata[q0 + i]), 64'(i));
      check($sformatf("t1_data%0d", i), mq_data[q0 + i], 64'hA0 + 64'(i));
      check($sformatf("t1_type%0d", i), 64'(mq_type[q0 + i]), 64'(eREQ_WRLINE_I));
    end
    if (FENCE == 0) check("t1_done_latency", 64'(done_cyc - last_ack_cyc), 64'd1);

    // T2: c1 almost-full held, 60 lines buffered, then release
    d0 = done_cnt;
    q0 = mq_addr.size();
    c1TxAlmFull = 1'b1;
    start_op(32'd0, 32'd100, 42'h2000);
    for (int i = 0; i < 60; i++) put_line(64'h2000_0000 + 64'(i), 1'b0);
    tick(140);
    check("t2_put_almfull", 64'(put_c1TxAlmFull), 64'd1);
    check("t2_no_c1_traffic", 64'(mq_addr.size() - q0), 64'd0);
    check("t2_no_early_done", 64'(done_cnt - d0), 64'd0);
    c1TxAlmFull = 1'b0;
    for (int i = 60; i < 100; i++) put_line(64'h2000_0000 + 64'(i), 1'b1);
    wait_done("t2_done", d0, 1000);
    tick(2);
    check("t2_req_count", 64'(mq_addr.size() - q0), 64'(100 + FENCE));
    for (int i = 0; i < 100; i++) begin
      check($sformatf("t2_addr%0d", i), 64'(mq_addr[q0 + i]), 64'h2000 + 64'(i));
      check($sformatf("t2_data%0d", i), mq_data[q0 + i], 64'h2000_0000 + 64'(i));
    end

    // T3: 8 lines acked by two packed responses of 4
    auto_ack = 1'b0;
    d0 = done_cnt;
    q0 = mq_addr.size();
    w0 = wr_cnt;
    start_op(32'd0, 32'd8, 42'h4000);
    for (int i = 0; i < 8; i++) put_line(64'h4000 + 64'(i), 1'b1);
    t = 0;
    while (wr_cnt - w0 < 8 && t < 100) begin
      tick();
      t++;
    end
    check("t3_writes_issued", 64'(wr_cnt - w0), 64'd8);
    tick(3);
    check("t3_no_done_unacked", 64'(done_cnt - d0), 64'd0);
    pack_req = pack_req + 1;
    tick(4);
    check("t3_no_done_half", 64'(done_cnt - d0), 64'd0);
    pack_req = pack_req + 1;
    wait_done("t3_done", d0, 100);
    if (FENCE == 0) check("t3_done_latency", 64'(done_cyc - last_ack_cyc), 64'd1);
    tick(2);

    // T4: zero-length operation
    auto_ack = 1'b1;
    d0 = done_cnt;
    q0 = mq_addr.size();
    start_op(32'd0, 32'd0, 42'h5000);
    wait_done("t4_done", d0, 50);
    tick(2);
    check("t4_req_count", 64'(mq_addr.size() - q0), 64'(FENCE));
    if (FENCE == 0) check("t4_done_latency", 64'(done_cyc - start_cyc), 64'd2);

    // T5: reset after 3 of 10 lines, then a clean run
    d0 = done_cnt;
    q0 = mq_addr.size();
    start_op(32'd0, 32'd10, 42'h6000);
    for (int i = 0; i < 3; i++) put_line(64'h6000 + 64'(i), 1'b1);
    tick(5);
    check("t5_partial_writes", 64'(mq_addr.size() - q0), 64'd3);
    resetn = 1'b0;
    #1;
    check("t5_rst_c1_valid", 64'(af2cp_sTx_c1.valid), 64'd0);
    check("t5_rst_put_almfull", 64'(put_c1TxAlmFull), 64'd1);
    check("t5_rst_op_done", 64'(op_done), 64'd0);
    check("t5_rst_rsp_fwd", 64'(put_cp2af_sRx_c1.rspValid), 64'd0);
    tick();
    resetn = 1'b1;
    tick(20);
    check("t5_no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    q0 = mq_addr.size();
    start_op(32'd0, 32'd2, 42'h7000);
    for (int i = 0; i < 2; i++) put_line(64'h7000 + 64'(i), 1'b1);
    wait_done("t5_rerun_done", d0, 100);
    tick(2);
    check("t5_rerun_count", 64'(mq_addr.size() - q0), 64'(2 + FENCE));
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t5_addr%0d", i), 64'(mq_addr[q0 + i]), 64'h7000 + 64'(i));
      check($sformatf("t5_mdata%0d", i), 64'(mq_mdata[q0 + i]), 64'(i));
    end

`ifdef WRITEBACK_FENCE_EN
    // T6: two lines followed by a write fence
    d0 = done_cnt;
    q0 = mq_addr.size();
    start_op(32'd0, 32'd2, 42'h8000);
    for (int i = 0; i < 2; i++) put_line(64'h8000 + 64'(i), 1'b1);
    wait_done("t6_done", d0, 100);
    tick(2);
    check("t6_req_count", 64'(mq_addr.size() - q0), 64'd3);
    check("t6_type0", 64'(mq_type[q0]), 64'(eREQ_WRLINE_I));
    check("t6_type1", 64'(mq_type[q0 + 1]), 64'(eREQ_WRLINE_I));
    check("t6_type_fence", 64'(mq_type[q0 + 2]), 64'(eREQ_WRFENCE));
    check("t6_fence_mdata", 64'(mq_mdata[q0 + 2]), 64'hFFFF);
    check("t6_done_after_fence", 64'(done_cyc - fence_rsp_cyc), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
